// File: rtl/plic_src_conditioner_pkg.sv
// Shared constants and helpers for the PLIC source conditioning stage.
// Default source count and synchroniser/filter depths used by the PLIC integration.
package plic_src_conditioner_pkg;

  localparam int PLIC_SOURCES         = 64;
  localparam int PLIC_MIN_SYNC_STAGES = 2;
  localparam int PLIC_SYNC_STAGES     = 2;
  localparam int PLIC_FILTER_CYCLES   = 4;

  // What the glitch filter does with a source on the current cycle.
  typedef enum logic [1:0] {
    FILT_FOLLOW,  // filter disabled: output tracks the sample directly
    FILT_HOLD,    // sample matches output: clear the stability count
    FILT_COUNT,   // sample differs, not yet stable long enough
    FILT_COMMIT   // sample differed for FILTER_CYCLES samples: take it
  } filt_act_e;

  // The counter needs at least one bit even when FILTER_CYCLES is 1.
  function automatic int filt_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/plic_src_filter.sv
// One interrupt source: synchroniser, polarity inversion and glitch filter.
// Registered src and src_rise outputs keep every output path flop-to-port.
module plic_src_filter
  import plic_src_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES   = PLIC_SYNC_STAGES,
  parameter int FILTER_CYCLES = PLIC_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_src_async,
  input  logic i_polarity,
  input  logic i_filter_en,
  output logic o_src,
  output logic o_src_rise
);

  localparam int             CNT_W    = filt_cnt_width(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   r_src;
  logic                   r_src_rise;
  logic                   w_sample;
  logic                   w_src_next;
  filt_act_e              w_act;

  assign w_sample = r_sync[SYNC_STAGES-1] ^ i_polarity;

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    w_act      = FILT_HOLD;
    w_src_next = r_src;
    w_cnt_next = '0;

    if (!i_filter_en) begin
      w_act = FILT_FOLLOW;
    end else if (w_sample == r_src) begin
      w_act = FILT_HOLD;
    end else if (r_cnt == LAST_CNT) begin
      w_act = FILT_COMMIT;
    end else begin
      w_act = FILT_COUNT;
    end

    case (w_act)
      FILT_FOLLOW: w_src_next = w_sample;
      FILT_HOLD:   w_cnt_next = '0;
      FILT_COUNT:  w_cnt_next = r_cnt + 1'b1;
      FILT_COMMIT: w_src_next = w_sample;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so the synchroniser
  // shifts one stage per edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync     <= '0;
      r_cnt      <= '0;
      r_src      <= 1'b0;
      r_src_rise <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_src_async};
      r_cnt      <= w_cnt_next;
      r_src      <= w_src_next;
      r_src_rise <= w_src_next & ~r_src;
    end
  end

  assign o_src      = r_src;
  assign o_src_rise = r_src_rise;

endmodule

// File: rtl/plic_src_conditioner.sv
// Conditions raw interrupt lines into the clean, registered PLIC src vector.
// Sources are independent; one plic_src_filter instance per line.
module plic_src_conditioner
  import plic_src_conditioner_pkg::*;
#(
  parameter int SOURCES       = PLIC_SOURCES,
  parameter int SYNC_STAGES   = PLIC_SYNC_STAGES,
  parameter int FILTER_CYCLES = PLIC_FILTER_CYCLES
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic [SOURCES-1:0] src_async,
  input  logic [SOURCES-1:0] polarity,
  input  logic [SOURCES-1:0] filter_en,
  output logic [SOURCES-1:0] src,
  output logic [SOURCES-1:0] src_rise
);

  if (SYNC_STAGES < PLIC_MIN_SYNC_STAGES) begin : g_bad_sync_stages
    $error("plic_src_conditioner: SYNC_STAGES must be at least %0d", PLIC_MIN_SYNC_STAGES);
  end

  if (FILTER_CYCLES < 1) begin : g_bad_filter_cycles
    $error("plic_src_conditioner: FILTER_CYCLES must be at least 1");
  end

  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    plic_src_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
      .clk         (PCLK),
      .rst_n       (PRESETn),
      .i_src_async (src_async[i]),
      .i_polarity  (polarity[i]),
      .i_filter_en (filter_en[i]),
      .o_src       (src[i]),
      .o_src_rise  (src_rise[i])
    );
  end

endmodule

// File: tb/tb_plic_src_conditioner.sv
// Directed and randomized bench for plic_src_conditioner against a run-length
// reference model of the synchronise / invert / filter behaviour.
module tb_plic_src_conditioner;

  localparam int SOURCES       = 64;
  localparam int SYNC_STAGES   = 2;
  localparam int FILTER_CYCLES = 4;

  logic               PCLK = 1'b0;
  logic               PRESETn;
  logic [SOURCES-1:0] src_async;
  logic [SOURCES-1:0] polarity;
  logic [SOURCES-1:0] filter_en;
  logic [SOURCES-1:0] src;
  logic [SOURCES-1:0] src_rise;

  int checks = 0;
  int errors = 0;

  // Reference model: raw inputs delayed SYNC_STAGES edges, plus the length of
  // the current run of identical samples per source.
  logic [SOURCES-1:0] m_pipe [SYNC_STAGES];
  logic [SOURCES-1:0] m_src;
  logic [SOURCES-1:0] m_rise;
  logic [SOURCES-1:0] m_prev_s;
  int                 m_run [SOURCES];

  always #5 PCLK = ~PCLK;

  plic_src_conditioner #(
    .SOURCES       (SOURCES),
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .src_async (src_async),
    .polarity  (polarity),
    .filter_en (filter_en),
    .src       (src),
    .src_rise  (src_rise)
  );

  task automatic check(input string tag, input logic [SOURCES-1:0] obs, input logic [SOURCES-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < SYNC_STAGES; k++) m_pipe[k] = '0;
    m_src    = '0;
    m_rise   = '0;
    m_prev_s = '0;
    for (int i = 0; i < SOURCES; i++) m_run[i] = 0;
  endfunction

  // A filtered source adopts the sample once FILTER_CYCLES consecutive
  // samples all disagree with the current output.
  function automatic void model_edge();
    logic [SOURCES-1:0] s;
    logic [SOURCES-1:0] nxt;
    s   = m_pipe[SYNC_STAGES-1] ^ polarity;
    nxt = m_src;
    for (int i = 0; i < SOURCES; i++) begin
      if (m_run[i] > 0 && s[i] == m_prev_s[i]) m_run[i]++;
      else                                     m_run[i] = 1;
      if (!filter_en[i] || (s[i] != m_src[i] && m_run[i] >= FILTER_CYCLES))
        nxt[i] = s[i];
    end
    m_rise   = nxt & ~m_src;
    m_src    = nxt;
    m_prev_s = s;
    for (int k = SYNC_STAGES - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = src_async;
  endfunction

  // Advance n edges, update the model, and compare both outputs 1 ns later.
  task automatic step(input string tag, input int n);
    repeat (n) begin
      @(posedge PCLK);
      if (PRESETn) model_edge();
      else         model_reset();
      #1;
      check({tag, "_src"}, src, m_src);
      check({tag, "_rise"}, src_rise, m_rise);
    end
  endtask

  initial begin
    logic [SOURCES-1:0] flips;

    // Reset with all lines high.
    PRESETn   = 1'b0;
    src_async = '1;
    polarity  = '0;
    filter_en = '0;
    model_reset();
    #1;
    check("rst_src_now", src, '0);
    check("rst_rise_now", src_rise, '0);
    step("in_rst", 3);
    PRESETn = 1'b1;
    step("rst_rel", 2);
    check("rst_lat2", src, '0);
    step("rst_rel", 1);
    check("rst_lat3_src", src, '1);
    check("rst_lat3_rise", src_rise, '1);
    step("rst_rel", 1);
    check("rst_rise_once", src_rise, '0);

    // Bring everything low, then filtered rise on source 3.
    src_async = '0;
    step("settle", 4);
    check("settle_low", src, '0);
    filter_en[3] = 1'b1;
    src_async[3] = 1'b1;
    step("frise", 5);
    check_bit("frise_e5", src[3], 1'b0);
    step("frise", 1);
    check_bit("frise_e6_src", src[3], 1'b1);
    check_bit("frise_e6_rise", src_rise[3], 1'b1);
    step("frise", 1);
    check_bit("frise_e7_rise", src_rise[3], 1'b0);
    check_bit("frise_e7_src", src[3], 1'b1);

    // Glitch rejection on source 5: 3-cycle pulse, then a 4-cycle pulse.
    filter_en[5] = 1'b1;
    src_async[5] = 1'b1;
    step("glitch3", 3);
    src_async[5] = 1'b0;
    step("glitch3", 6);
    check_bit("glitch3_low", src[5], 1'b0);
    src_async[5] = 1'b1;
    step("pulse4", 4);
    src_async[5] = 1'b0;
    step("pulse4", 1);
    check_bit("pulse4_e5", src[5], 1'b0);
    step("pulse4", 1);
    check_bit("pulse4_e6", src[5], 1'b1);
    step("pulse4", 3);
    check_bit("pulse4_e9", src[5], 1'b1);
    step("pulse4", 1);
    check_bit("pulse4_e10", src[5], 1'b0);

    // Active-low source 0.
    filter_en[0] = 1'b1;
    polarity[0]  = 1'b1;
    src_async[0] = 1'b1;
    step("pol_idle", 8);
    check_bit("pol_idle", src[0], 1'b0);
    src_async[0] = 1'b0;
    step("pol_act", 5);
    check_bit("pol_e5", src[0], 1'b0);
    step("pol_act", 1);
    check_bit("pol_e6", src[0], 1'b1);

    // Mid-count disable on source 7.
    filter_en[7] = 1'b1;
    src_async[7] = 1'b1;
    step("midcnt", 4);
    check_bit("midcnt_hold", src[7], 1'b0);
    filter_en[7] = 1'b0;
    step("midcnt", 1);
    check_bit("midcnt_src", src[7], 1'b1);
    check_bit("midcnt_rise", src_rise[7], 1'b1);
    filter_en[7] = 1'b1;
    step("reen", 3);
    check_bit("reen_no_rise", src_rise[7], 1'b0);
    check_bit("reen_src", src[7], 1'b1);

    // Random independent activity on all sources.
    filter_en = {$urandom, $urandom};
    for (int c = 0; c < 300; c++) begin
      flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      src_async = src_async ^ flips;
      if (c % 40 == 39) filter_en = {$urandom, $urandom};
      if (c % 75 == 74) polarity  = {$urandom, $urandom};
      step("rand", 1);
    end

    // Reset in the middle of counting.
    filter_en = '1;
    src_async = ~src_async;
    step("pre_rst", 4);
    #2;
    PRESETn = 1'b0;
    model_reset();
    #1;
    check("midrst_src_now", src, '0);
    check("midrst_rise_now", src_rise, '0);
    step("midrst", 3);
    PRESETn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      src_async = src_async ^ flips;
      if (c % 50 == 49) filter_en = {$urandom, $urandom};
      step("post_rst", 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
